regfile_sb: RTL

//   Parametrised integer register file with N combinational read ports, one clocked write port,

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_sb_busy_bits.sv | 57 +++++
 rtl/regfile_sb.sv | 71 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its busy scoreboard.
package regfile_pkg;

    // Default integer data width.
    localparam int RF_XLEN = 32;

    // Architectural register that always reads as zero.
    localparam int RF_ZERO_IDX = 0;

    // Index width for a register file of nregs entries (ceil(log2(nregs))).
    function automatic int rf_idxw(input int nregs);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < nregs) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_sb_busy_bits.sv
// Per-register busy scoreboard: flush > issue > writeback priority, plus a
// registered count of pending destinations.
module sb_busy_bits
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_en,
    input  logic [IDXW-1:0]  issue_idx,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [IDXW:0]    pending_cnt
);

    logic [NREGS-1:0] busy_nxt;
    logic [IDXW:0]    cnt_nxt;

    // Next busy vector; issue is applied after writeback so a new producer wins.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_en && (wr_idx != IDXW'(RF_ZERO_IDX))) begin
                busy_nxt[wr_idx] = 1'b0;
            end
            if (issue_en && (issue_idx != IDXW'(RF_ZERO_IDX))) begin
                busy_nxt[issue_idx] = 1'b1;
            end
        end
    end

    // Popcount of the next busy vector so the count tracks busy after every edge.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + {{IDXW{1'b0}}, busy_nxt[i]};
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: NREAD combinational read ports with same-cycle
// write-through bypass, one clocked write port, and a busy scoreboard.
// Register 0 is hardwired to zero and can never be marked busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int IDXW = rf_idxw(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*IDXW-1:0] rd_idx,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [IDXW-1:0]       wr_idx,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  issue_en,
    input  logic [IDXW-1:0]       issue_idx,
    input  logic                  flush,
    output logic [IDXW:0]         pending_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    // Data array; writes to register 0 are dropped so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_idx != IDXW'(RF_ZERO_IDX))) begin
            regs[wr_idx] <= wr_data;
        end
    end

    sb_busy_bits #(
        .NREGS (NREGS),
        .IDXW  (IDXW)
    ) u_busy (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_en    (issue_en),
        .issue_idx   (issue_idx),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .flush       (flush),
        .busy        (busy),
        .pending_cnt (pending_cnt)
    );

    // Read ports: zero register, then bypass from the writeback, then storage.
    // A register being written this cycle is no longer busy from the reader's view.
    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [IDXW-1:0] idx;
        logic            is_zero;
        logic            hit;

        assign idx     = rd_idx[p*IDXW +: IDXW];
        assign is_zero = (idx == IDXW'(RF_ZERO_IDX));
        assign hit     = wr_en && (wr_idx == idx);

        assign rd_data[p*XLEN +: XLEN] = is_zero ? '0 :
                                         hit     ? wr_data : regs[idx];
        assign rd_busy[p] = !is_zero && busy[idx] && !hit;
    end

endmodule
